// File: rtl/dff_pkg.sv
`timescale 1ns/1ps
// dff_pkg
// Shared defaults for the dff leaf flop and its interface bundle.
//   DFF_WIDTH   : default data width of din/dout
//   DFF_RST_VAL : default value loaded into dout while rst is high
//   dff_data_t  : data word at the default width
package dff_pkg;

   localparam int DFF_WIDTH = 1;
   localparam logic [DFF_WIDTH-1:0] DFF_RST_VAL = '0;

   typedef logic [DFF_WIDTH-1:0] dff_data_t;

endpackage

// File: rtl/dff_interface.sv
`timescale 1ns/1ps
// dff_interface
// Signal bundle between the dff flop and its environment.
//   clk  : rising-edge clock, driven by the environment
//   rst  : synchronous active-high reset
//   din  : data input  [WIDTH-1:0]
//   dout : registered data output [WIDTH-1:0]
// Modports: DUT (flop side) and TB (environment side, with clocking block).
// Simulation-only checkers and cover points sit behind SYNTHESIS.
interface dff_interface
   import dff_pkg::*;
#(
   parameter int                 WIDTH   = DFF_WIDTH,
   parameter logic [WIDTH-1:0]   RST_VAL = DFF_RST_VAL
);

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;

   modport DUT (
      input  clk,
      input  rst,
      input  din,
      output dout
   );

`ifndef SYNTHESIS
   clocking cb @(posedge clk);
      default input #1 output #1;
      input  dout;
      output din;
      output rst;
   endclocking

   modport TB (
      clocking cb,
      output clk,
      output rst,
      output din,
      input  dout
   );

   // Goes high at the first reset edge; dout is only meaningful after that.
   logic rst_seen;

   always_ff @(posedge clk) begin
      if (rst) begin
         rst_seen <= 1'b1;
      end
   end

   a_rst_load: assert property (@(posedge clk) rst |=> dout == RST_VAL)
      else $error("dff_interface: dout not at reset value one edge after rst");

   a_capture: assert property (@(posedge clk) !rst |=> dout == $past(din))
      else $error("dff_interface: dout does not follow din sampled one edge earlier");

   a_no_x: assert property (@(posedge clk) rst_seen |-> !$isunknown(dout))
      else $error("dff_interface: dout unknown after reset");

   c_rst:          cover property (@(posedge clk) rst);
   c_din_zero:     cover property (@(posedge clk) !rst && din == '0);
   c_din_ones:     cover property (@(posedge clk) !rst && din == '1);
   c_rst_then_cap: cover property (@(posedge clk) rst ##1 !rst);
`else
   modport TB (
      output clk,
      output rst,
      output din,
      input  dout
   );
`endif

endinterface

// File: rtl/dff.sv
`timescale 1ns/1ps
// dff
// Leaf D flip-flop, one cycle latency, synchronous active-high reset.
// Ports (through vif, modport DUT):
//   vif.clk  : rising-edge clock
//   vif.rst  : synchronous reset, loads RST_VAL and overrides din
//   vif.din  : data input  [WIDTH-1:0]
//   vif.dout : registered output [WIDTH-1:0]
// WIDTH and RST_VAL must match the connected dff_interface instance.
module dff
   import dff_pkg::*;
#(
   parameter int                 WIDTH   = DFF_WIDTH,
   parameter logic [WIDTH-1:0]   RST_VAL = DFF_RST_VAL
) (
   dff_interface.DUT vif
);

   always_ff @(posedge vif.clk) begin
      if (vif.rst) begin
         vif.dout <= RST_VAL;
      end else begin
         vif.dout <= vif.din;
      end
   end

endmodule

// File: tb/tb_dff.sv
`timescale 1ns/1ps
// tb_dff
// Directed table plus hand sequences and a short random run against two
// dff instances: the default 1-bit flop and an 8-bit flop with RST_VAL 8'hA5.
module tb_dff;
   import dff_pkg::*;

   localparam logic [7:0] RST8 = 8'hA5;
   localparam int         NVEC = 13;

   int checks = 0;
   int errors = 0;

   dff_interface #(.WIDTH(1), .RST_VAL(1'b0)) dif ();
   dff_interface #(.WIDTH(8), .RST_VAL(RST8)) dif8 ();

   dff #(.WIDTH(1), .RST_VAL(1'b0)) u_dut  (.vif(dif));
   dff #(.WIDTH(8), .RST_VAL(RST8)) u_dut8 (.vif(dif8));

   initial begin
      dif.clk  = 1'b0;
      dif8.clk = 1'b0;
      forever begin
         #10;
         dif.clk  = ~dif.clk;
         dif8.clk = ~dif8.clk;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got no summary, required finish before 100000ns");
      $fatal(1, "tb_dff watchdog expired");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge dif.clk);
      #1;
   endtask

   typedef struct packed {
      logic rst;
      logic din;
      logic exp;
   } vec_t;

   vec_t       vecs [NVEC];
   logic [7:0] d8;
   logic [7:0] exp8;
   logic       r;
   logic       d;

   initial begin
      // reset x2, capture 1, toggle 0,1,1,0, then 1, reset, recover, reset with din 0, recover
      vecs[0]  = '{rst: 1'b1, din: 1'b1, exp: 1'b0};
      vecs[1]  = '{rst: 1'b1, din: 1'b1, exp: 1'b0};
      vecs[2]  = '{rst: 1'b0, din: 1'b1, exp: 1'b1};
      vecs[3]  = '{rst: 1'b0, din: 1'b0, exp: 1'b0};
      vecs[4]  = '{rst: 1'b0, din: 1'b1, exp: 1'b1};
      vecs[5]  = '{rst: 1'b0, din: 1'b1, exp: 1'b1};
      vecs[6]  = '{rst: 1'b0, din: 1'b0, exp: 1'b0};
      vecs[7]  = '{rst: 1'b0, din: 1'b1, exp: 1'b1};
      vecs[8]  = '{rst: 1'b1, din: 1'b1, exp: 1'b0};
      vecs[9]  = '{rst: 1'b0, din: 1'b1, exp: 1'b1};
      vecs[10] = '{rst: 1'b1, din: 1'b0, exp: 1'b0};
      vecs[11] = '{rst: 1'b0, din: 1'b0, exp: 1'b0};
      vecs[12] = '{rst: 1'b0, din: 1'b1, exp: 1'b1};

      for (int i = 0; i < NVEC; i++) begin
         dif.rst  = vecs[i].rst;
         dif.din  = vecs[i].din;
         d8       = vecs[i].din ? 8'h3C : 8'hC3;
         dif8.rst = vecs[i].rst;
         dif8.din = d8;
         if (i > 0) begin
            #5;
            check($sformatf("hold_before_edge_%0d", i), {7'b0, dif.dout}, {7'b0, vecs[i-1].exp});
         end
         tick();
         check($sformatf("vec_%0d", i), {7'b0, dif.dout}, {7'b0, vecs[i].exp});
         check($sformatf("vec8_%0d", i), dif8.dout, vecs[i].rst ? RST8 : d8);
      end

      // din held at 1, single reset edge at cycle 5, capture resumes at cycle 6
      for (int c = 1; c <= 7; c++) begin
         dif.rst  = (c == 5);
         dif.din  = 1'b1;
         dif8.rst = (c == 5);
         dif8.din = 8'hFF;
         tick();
         check($sformatf("midreset_c%0d", c), {7'b0, dif.dout}, (c == 5) ? 8'h00 : 8'h01);
         check($sformatf("midreset8_c%0d", c), dif8.dout, (c == 5) ? RST8 : 8'hFF);
      end

      // rst pulse and din toggle strictly between edges must not reach dout
      #4;
      dif.rst  = 1'b1;
      dif.din  = 1'b0;
      dif8.rst = 1'b1;
      dif8.din = 8'h00;
      #4;
      dif.rst  = 1'b0;
      dif.din  = 1'b1;
      dif8.rst = 1'b0;
      dif8.din = 8'hFF;
      check("glitch_hi_between", {7'b0, dif.dout}, 8'h01);
      check("glitch8_between", dif8.dout, 8'hFF);
      tick();
      check("glitch_hi_after_edge", {7'b0, dif.dout}, 8'h01);
      check("glitch8_after_edge", dif8.dout, 8'hFF);

      dif.din = 1'b0;
      tick();
      check("glitch_lo_setup", {7'b0, dif.dout}, 8'h00);
      #4;
      dif.rst = 1'b1;
      dif.din = 1'b1;
      #4;
      dif.rst = 1'b0;
      dif.din = 1'b0;
      check("glitch_lo_between", {7'b0, dif.dout}, 8'h00);
      tick();
      check("glitch_lo_after_edge", {7'b0, dif.dout}, 8'h00);

      // random regression, rst roughly one edge in ten
      for (int t = 0; t < 30; t++) begin
         r  = ($urandom_range(0, 9) == 0);
         d  = 1'($urandom_range(0, 1));
         d8 = 8'($urandom_range(0, 255));
         dif.rst  = r;
         dif.din  = d;
         dif8.rst = r;
         dif8.din = d8;
         tick();
         exp8 = r ? RST8 : d8;
         check($sformatf("rand_%0d", t), {7'b0, dif.dout}, r ? 8'h00 : {7'b0, d});
         check($sformatf("rand8_%0d", t), dif8.dout, exp8);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
